// File: rtl/uart_ram_dump.sv
`timescale 1ns/1ps
// uart_ram_dump: reads a window of system RAM one byte at a time through the
// ask-for-RAM arbiter and sends each byte out as 8N1 UART on serial_txd.
// The RAM is requested only while a single byte is being fetched, so the CPU
// stalls for a few cycles per byte instead of for the whole dump.
module uart_ram_dump #(
  parameter int ADDR_WIDTH   = 11,
  parameter int CLKS_PER_BIT = 436
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  ask_for_ram,
  input  logic                  ram_grant,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [7:0]            ram_rdata,
  output logic                  serial_txd,
  output logic                  busy,
  output logic                  done
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST  = 4'd9;
  localparam logic [ADDR_WIDTH:0] ONE_LEFT = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LATCH,
    S_TX,
    S_NEXT
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [9:0]            frame_q, frame_d;       // start, 8 data LSB first, stop
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic                  txd_q, txd_d;
  logic                  ask_q, ask_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Next-state and next-output logic for the fetch/transmit sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    frame_d     = frame_q;
    bit_cnt_d   = bit_cnt_q;
    baud_cnt_d  = baud_cnt_q;
    txd_d       = txd_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (start) begin
          addr_d      = start_addr;
          remaining_d = length;
          if (length == '0) begin
            done_d = 1'b1;              // empty dump completes immediately
          end else begin
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (ram_grant) state_d = S_WAIT;
      end

      S_WAIT: begin
        // Grant lost during the RAM latency cycle: the data is suspect, so
        // go back and fetch the same address again.
        state_d = ram_grant ? S_LATCH : S_REQ;
      end

      S_LATCH: begin
        frame_d    = {1'b1, ram_rdata, 1'b0};
        txd_d      = 1'b0;                // start bit goes out next cycle
        bit_cnt_d  = '0;
        baud_cnt_d = '0;
        state_d    = S_TX;
      end

      S_TX: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            txd_d   = 1'b1;
            state_d = S_NEXT;
            done_d  = (remaining_q == ONE_LEFT);  // this was the last byte
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            frame_d   = {1'b1, frame_q[9:1]};
            txd_d     = frame_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      S_NEXT: begin
        addr_d      = addr_q + ADDR_WIDTH'(1);   // wraps modulo 2^ADDR_WIDTH
        remaining_d = remaining_q - ONE_LEFT;
        state_d     = (remaining_q == ONE_LEFT) ? S_IDLE : S_REQ;
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    ask_d  = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_LATCH);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      frame_q     <= '1;
      bit_cnt_q   <= '0;
      baud_cnt_q  <= '0;
      txd_q       <= 1'b1;
      ask_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from the values
      // of the previous cycle, independent of statement order.
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      baud_cnt_q  <= baud_cnt_d;
      txd_q       <= txd_d;
      ask_q       <= ask_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ask_for_ram = ask_q;
  assign ram_raddr   = addr_q;
  assign serial_txd  = txd_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_uart_ram_dump.sv
`timescale 1ns/1ps
// Self-checking bench for uart_ram_dump: a registered RAM model that returns
// garbage without grant, a UART decoder feeding a byte scoreboard, an address
// scoreboard on each new request, and directed timing checks per scenario.
module tb_uart_ram_dump;

  localparam int AW    = 11;
  localparam int CPB   = 436;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic          ask_for_ram;
  logic          ram_grant;
  logic [AW-1:0] ram_raddr;
  logic [7:0]    ram_rdata;
  logic          serial_txd;
  logic          busy;
  logic          done;

  logic [7:0]    mem [0:2**AW-1];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0]    exp_data [$];
  logic [AW-1:0] exp_addr [$];
  int            start_log [$];

  int   ask_cnt  = 0;
  int   done_cnt = 0;
  logic ask_prev = 1'b0;

  uart_ram_dump #(.ADDR_WIDTH(AW), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .ask_for_ram(ask_for_ram),
    .ram_grant  (ram_grant),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata),
    .serial_txd (serial_txd),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered RAM; without grant the port returns junk.
  always @(posedge clk) ram_rdata <= ram_grant ? mem[ram_raddr] : 8'hEE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Request/done counters and address scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (ask_for_ram) ask_cnt++;
      if (done) done_cnt++;
      if (ask_for_ram && !ask_prev) begin
        check("req_expected", 32'(exp_addr.size() > 0), 32'd1);
        if (exp_addr.size() > 0) check("req_addr", 32'(ram_raddr), 32'(exp_addr.pop_front()));
      end
    end
    ask_prev = ask_for_ram;
  end

  task automatic mon_wait(input int n, inout bit ab);
    for (int i = 0; i < n && !ab; i++) begin
      @(negedge clk);
      if (reset) ab = 1'b1;
    end
  endtask

  task automatic decode_frame();
    bit         ab;
    logic [7:0] b;
    ab = 1'b0;
    b  = '0;
    start_log.push_back(cyc);
    mon_wait(CPB / 2, ab);
    if (ab) return;
    check("start_bit_mid", 32'(serial_txd), 32'd0);
    for (int i = 0; i < 8; i++) begin
      mon_wait(CPB, ab);
      if (ab) return;
      b[i] = serial_txd;
    end
    mon_wait(CPB, ab);
    if (ab) return;
    check("stop_bit", 32'(serial_txd), 32'd1);
    check("byte_expected", 32'(exp_data.size() > 0), 32'd1);
    if (exp_data.size() > 0) check("byte_data", 32'(b), 32'(exp_data.pop_front()));
  endtask

  // UART decoder: samples mid-bit on the falling clock edge.
  initial begin : uart_mon
    forever begin
      @(negedge clk);
      if (!reset && serial_txd == 1'b0) decode_frame();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_dump(input logic [AW-1:0] a, input int n);
    logic [AW-1:0] ad;
    ad = a;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(ad);
      exp_data.push_back(mem[ad]);
      ad = ad + AW'(1);
    end
  endtask

  // Presents start for one cycle; t0 is the cycle in which it is presented.
  task automatic pulse_start(input logic [AW-1:0] a, input logic [AW:0] n, output int t0);
    start_addr = a;
    length     = n;
    start      = 1'b1;
    t0         = cyc;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int t_done);
    int n;
    n      = 0;
    t_done = -1;
    while (n < budget) begin
      tick();
      n++;
      if (done) begin
        t_done = cyc;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(t_done >= 0), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_dump(input string tag, input int s0, input int nbytes,
                            input int first_cyc, input int t_done);
    check({tag, "_frames"}, 32'(start_log.size() - s0), 32'(nbytes));
    if (nbytes > 0 && start_log.size() >= s0 + nbytes) begin
      check({tag, "_first_start"}, 32'(start_log[s0]), 32'(first_cyc));
      for (int i = 1; i < nbytes; i++)
        check({tag, "_gap"}, 32'(start_log[s0+i] - start_log[s0+i-1]), 32'(FRAME + 4));
      check({tag, "_done_cyc"}, 32'(t_done), 32'(start_log[s0+nbytes-1] + FRAME));
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int         t0, t_done, s0, a0, d0, g0, target;
    logic [9:0] fr;

    reset      = 1'b1;
    start      = 1'b0;
    ram_grant  = 1'b1;
    start_addr = '0;
    length     = '0;
    for (int i = 0; i < 2**AW; i++) mem[i] = 8'(i * 37 + 5);
    repeat (3) tick();
    check("rst_txd", 32'(serial_txd), 32'd1);
    check("rst_ask", 32'(ask_for_ram), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_raddr", 32'(ram_raddr), 32'd0);
    reset = 1'b0;
    tick();

    // Single byte 0xA5 with grant tied high: bit-exact line check.
    mem[11'h200] = 8'hA5;
    s0 = start_log.size(); a0 = ask_cnt; d0 = done_cnt;
    expect_dump(11'h200, 1);
    pulse_start(11'h200, 12'd1, t0);
    check("t1_busy_rise", 32'(busy), 32'd1);
    check("t1_ask_rise", 32'(ask_for_ram), 32'd1);
    while (cyc < t0 + 3) tick();
    check("t1_idle_before_start", 32'(serial_txd), 32'd1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      while (cyc < t0 + 4 + k * CPB) tick();
      check("t1_bit_first", 32'(serial_txd), 32'(fr[k]));
      while (cyc < t0 + 4 + k * CPB + CPB - 1) tick();
      check("t1_bit_last", 32'(serial_txd), 32'(fr[k]));
    end
    wait_done("t1", 200, t_done);
    check_dump("t1", s0, 1, t0 + 4, t_done);
    check("t1_ask_cycles", 32'(ask_cnt - a0), 32'd3);
    repeat (5) tick();
    check("t1_done_count", 32'(done_cnt - d0), 32'd1);

    // Address wrap-around 0x7FE..0x001.
    mem[11'h7FE] = 8'h11; mem[11'h7FF] = 8'h22; mem[11'h000] = 8'h33; mem[11'h001] = 8'h44;
    s0 = start_log.size(); a0 = ask_cnt;
    expect_dump(11'h7FE, 4);
    pulse_start(11'h7FE, 12'd4, t0);
    wait_done("t2", 4 * (FRAME + 4) + 200, t_done);
    check_dump("t2", s0, 4, t0 + 4, t_done);
    check("t2_ask_cycles", 32'(ask_cnt - a0), 32'd12);

    // Grant withheld for 50 cycles after the request.
    mem[11'h0AB] = 8'hC3;
    repeat (3) tick();
    ram_grant = 1'b0;
    s0 = start_log.size(); a0 = ask_cnt;
    expect_dump(11'h0AB, 1);
    pulse_start(11'h0AB, 12'd1, t0);
    repeat (50) tick();
    check("t3_ask_held", 32'(ask_for_ram), 32'd1);
    check("t3_line_idle", 32'(serial_txd), 32'd1);
    check("t3_no_frame_yet", 32'(start_log.size() - s0), 32'd0);
    ram_grant = 1'b1;
    g0 = cyc;
    wait_done("t3", FRAME + 200, t_done);
    check_dump("t3", s0, 1, g0 + 3, t_done);
    check("t3_ask_cycles", 32'(ask_cnt - a0), 32'(g0 + 2 - t0));

    // Grant dropped for one cycle during WAIT: byte must be re-fetched.
    mem[11'h123] = 8'h3C;
    repeat (3) tick();
    s0 = start_log.size(); a0 = ask_cnt;
    expect_dump(11'h123, 1);
    pulse_start(11'h123, 12'd1, t0);
    tick();
    ram_grant = 1'b0;
    tick();
    ram_grant = 1'b1;
    check("t4_ask_rerequest", 32'(ask_for_ram), 32'd1);
    wait_done("t4", FRAME + 200, t_done);
    check_dump("t4", s0, 1, t0 + 6, t_done);
    check("t4_ask_cycles", 32'(ask_cnt - a0), 32'd5);

    // Zero length: done at T+1, never busy, line idle.
    repeat (3) tick();
    s0 = start_log.size(); a0 = ask_cnt; d0 = done_cnt;
    pulse_start(11'h050, 12'd0, t0);
    check("t5_done", 32'(done), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    tick();
    check("t5_done_once", 32'(done), 32'd0);
    check("t5_busy_after", 32'(busy), 32'd0);
    repeat (20) tick();
    check("t5_line_idle", 32'(serial_txd), 32'd1);
    check("t5_no_request", 32'(ask_cnt - a0), 32'd0);
    check("t5_no_frame", 32'(start_log.size() - s0), 32'd0);
    check("t5_done_count", 32'(done_cnt - d0), 32'd1);

    // Start while busy is ignored.
    s0 = start_log.size(); d0 = done_cnt;
    expect_dump(11'h300, 2);
    pulse_start(11'h300, 12'd2, t0);
    repeat (1000) tick();
    check("t6_busy_mid", 32'(busy), 32'd1);
    pulse_start(11'h400, 12'd5, g0);
    wait_done("t6", 2 * (FRAME + 4) + 200, t_done);
    check_dump("t6", s0, 2, t0 + 4, t_done);
    repeat (20) tick();
    check("t6_done_count", 32'(done_cnt - d0), 32'd1);
    check("t6_idle_after", 32'(busy), 32'd0);

    // Reset during bit 4 of the second byte, then a clean dump of 0x5A.
    mem[11'h600] = 8'h81; mem[11'h601] = 8'h00;
    expect_dump(11'h600, 2);
    pulse_start(11'h600, 12'd2, t0);
    target = t0 + 4 + (FRAME + 4) + 4 * CPB + 200;
    while (cyc < target) tick();
    check("t7_line_low_before_reset", 32'(serial_txd), 32'd0);
    reset = 1'b1;
    tick();
    check("t7_rst_txd", 32'(serial_txd), 32'd1);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_ask", 32'(ask_for_ram), 32'd0);
    check("t7_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    exp_data.delete();
    check("t7_addr_q_drained", 32'(exp_addr.size()), 32'd0);
    repeat (5) tick();
    mem[11'h010] = 8'h5A;
    s0 = start_log.size();
    expect_dump(11'h010, 1);
    pulse_start(11'h010, 12'd1, t0);
    wait_done("t7", FRAME + 200, t_done);
    check_dump("t7", s0, 1, t0 + 4, t_done);

    repeat (10) tick();
    check("end_data_q_empty", 32'(exp_data.size()), 32'd0);
    check("end_addr_q_empty", 32'(exp_addr.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_ram_dump.md
# uart_ram_dump

Serial memory-dump transmitter, the outbound counterpart of `uart_prog_input`. On a start pulse it reads a contiguous window of system RAM one byte at a time and sends each byte as 57600-baud 8N1 UART on `serial_txd`. RAM access uses the same ask-for-RAM arbitration as the program loader. `ask_for_ram` is held only while one byte is being fetched, so the CPU stalls for a few cycles per byte rather than for the whole dump.

## Interface
Parameters:
- `ADDR_WIDTH`, 11: RAM address width.
- `CLKS_PER_BIT`, 436: `clk` cycles per UART bit (25.125 MHz / 57600).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock (`CLK_25M` domain).
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a dump; ignored while `busy`.
- `start_addr`  in  ADDR_WIDTH  first RAM address; sampled on an accepted `start`.
- `length`  in  ADDR_WIDTH+1  number of bytes, 0..2^ADDR_WIDTH; sampled on an accepted `start`.
- `ask_for_ram`  out  1  RAM request to the arbiter.
- `ram_grant`  in  1  arbiter grant; RAM port is owned by this block while high.
- `ram_raddr`  out  ADDR_WIDTH  RAM read address.
- `ram_rdata`  in  8  RAM read data, valid one cycle after the address (registered RAM).
- `serial_txd`  out  1  UART line; idles high.
- `busy`  out  1  dump in progress.
- `done`  out  1  one-cycle pulse when a dump completes.

## Operation
- States: IDLE, REQ, WAIT, LATCH, TX, NEXT.
- IDLE:
  - `busy`=0.
  - On `start`: load `addr`<=`start_addr` and `remaining`<=`length`.
  - If `length`==0, pulse `done` and stay in IDLE; nothing is transmitted and `busy` never rises.
  - Otherwise go to REQ.
- REQ:
  - `ask_for_ram`=1 and `ram_raddr`=`addr`.
  - Stay until `ram_grant` is sampled 1, then go to WAIT.
- WAIT:
  - `ask_for_ram` stays 1 and `ram_raddr` is held for one cycle of RAM latency.
  - Go to LATCH.
- LATCH:
  - Capture `ram_rdata` into the shift register.
  - `ask_for_ram`=0 from the next cycle on.
  - Go to TX.
- TX:
  - Send a 10-bit frame: start bit 0, then data bits LSB first, then stop bit 1.
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - Use a bit counter 0..9 and a baud counter 0..CLKS_PER_BIT-1.
  - After the stop bit ends, go to NEXT.
- NEXT:
  - `addr`<=`addr`+1, wrapping modulo 2^ADDR_WIDTH (0x7FF to 0x000 at default width).
  - `remaining`<=`remaining`-1.
  - If the new `remaining`==0: pulse `done`, go to IDLE.
  - Otherwise go to REQ.
- `ram_raddr` holds `addr` in every state.
- Loss of grant: if `ram_grant` drops during WAIT, return to REQ and keep `ask_for_ram` high. The byte is re-fetched; no bad byte is sent.
- Simultaneous `start` and `reset`: reset wins.
- Reset mid-operation, on the next edge:
  - State returns to IDLE.
  - `serial_txd`=1, `ask_for_ram`=0, `busy`=0, `done`=0.
  - A truncated frame is allowed.

## Timing
- Reset values: `serial_txd`=1, `ask_for_ram`=0, `busy`=0, `done`=0, `ram_raddr`=0.
- All outputs are registered.
- `start` accepted on edge T: `busy`=1 and `ask_for_ram`=1 from T+1.
- With grant already high at T+1: WAIT at T+2, LATCH at T+3.
- `serial_txd` falls (start bit) at T+4.
- `ask_for_ram` is low from T+4.
- Frame length is 10×CLKS_PER_BIT = 4360 cycles.
- Inter-byte gap with grant held high: 4 cycles of idle-high line (NEXT, REQ, WAIT, LATCH).
- `done` pulses for one cycle in NEXT, one cycle after the last stop bit ends.
- `busy` drops in the cycle after `done`.
- For `length`==0: `done` pulses at T+1 and `busy` stays 0.

## Test plan
- Single byte:
  - Stimulus: RAM[0x200]=0xA5, `start_addr`=0x200, `length`=1, grant tied high.
  - Response: `serial_txd` = 0,1,0,1,0,0,1,0,1,1, each bit 436 cycles, start bit at T+4.
  - `done` pulses once; `ask_for_ram` is high for exactly 3 cycles.
- Wrap-around:
  - Stimulus: `start_addr`=0x7FE, `length`=4, RAM preloaded with 0x11, 0x22, 0x33, 0x44 at 0x7FE, 0x7FF, 0x000, 0x001.
  - Response: the four bytes are decoded in that order; `ram_raddr` goes 0x7FE, 0x7FF, 0x000, 0x001.
- Delayed grant:
  - Stimulus: `ram_grant` held low for 50 cycles after the request.
  - Response: `ask_for_ram` stays high, `serial_txd` stays 1, and the start bit appears 3 cycles after grant.
- Grant drop:
  - Stimulus: `ram_grant` drops for 1 cycle during WAIT.
  - Response: the block re-requests and the correct byte is still sent.
- Zero length and busy start:
  - Stimulus: `length`=0.
  - Response: `done` at T+1, `busy` 0, line idle.
  - Stimulus: a second `start` mid-dump.
  - Response: ignored; byte count is unchanged.
- Reset mid-frame:
  - Stimulus: `reset` at bit 4 of byte 2.
  - Response: next edge gives `serial_txd`=1, `busy`=0, `ask_for_ram`=0.
  - A following dump of 0x5A decodes correctly.
